// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift per clock under a start/busy/done handshake. A conversion takes
// WIDTH cycles after acceptance, and the result is held until the next
// completion. Values >= 10**DIGITS return the value mod 10**DIGITS and raise
// overflow.
module bin2bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bin_sr;
    logic [BW-1:0]     scratch;
    logic [CW-1:0]     cnt;
    logic              sticky;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     scratch_next;
    logic [WIDTH-1:0]  bin_next;
    logic              carry_out;
    logic              sticky_next;

    // Add-3 correction: each digit >= 5 gets +3, kept within its own nibble.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    // The scratch MSB falls off the top; if it is ever 1, a significant
    // digit beyond DIGITS was lost.
    assign carry_out                 = adj[BW-1];
    assign {scratch_next, bin_next}  = {adj[BW-2:0], bin_sr, 1'b0};
    assign sticky_next               = sticky | carry_out;

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= bin_in;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        sticky  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    bin_sr  <= bin_next;
                    sticky  <= sticky_next;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        // Last shift: publish result; the done cycle is already IDLE
                        // so a back-to-back start is accepted there.
                        bcd_out  <= scratch_next;
                        overflow <= sticky_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 4-digit and a 2-digit instance share
// the same stimulus. Expected results come from decimal arithmetic on the
// accepted value and are queued at acceptance; a negedge monitor checks
// busy/done every cycle and pops/compares on each done pulse.
module tb_bin2bcd_seq;

    localparam int WIDTH = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  bin_in = '0;

    logic              busy_a, done_a, ovf_a;
    logic [15:0]       bcd_a;
    logic              busy_b, done_b, ovf_b;
    logic [7:0]        bcd_b;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
    );

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: remaining busy cycles and done flag.
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    logic [16:0] hold_a = '0;
    logic [16:0] hold_b = '0;

    // {overflow, bcd} for value v shown on dg decimal digits.
    function automatic logic [16:0] ref_of(int v, int dg);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < dg; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return {(v >= 10**dg) ? 1'b1 : 1'b0, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: the model follows the handshake rules at the edge, inputs
    // may then be changed 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (m_cnt == 0) begin
            m_done = 1'b0;
            if (start) begin
                m_cnt = WIDTH;
                qa.push_back(ref_of(int'(bin_in), 4));
                qb.push_back(ref_of(int'(bin_in), 2));
            end
        end else begin
            m_cnt--;
            m_done = (m_cnt == 0);
        end
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        m_cnt  = 0;
        m_done = 1'b0;
        qa.delete();
        qb.delete();
        hold_a = '0;
        hold_b = '0;
    endtask

    task automatic convert(input int v);
        bin_in = WIDTH'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (WIDTH + 2) tick();
    endtask

    // Monitor: per-cycle handshake checks and result comparison on done.
    initial forever begin
        @(negedge clk);
        chk("busy_a", busy_a, m_cnt != 0);
        chk("busy_b", busy_b, m_cnt != 0);
        chk("done_a", done_a, m_done);
        chk("done_b", done_b, m_done);
        if (done_a) begin
            if (qa.size() == 0) chk("spurious_done_a", 1, 0);
            else hold_a = qa.pop_front();
        end
        if (done_b) begin
            if (qb.size() == 0) chk("spurious_done_b", 1, 0);
            else hold_b = qb.pop_front();
        end
        chk("bcd_a", bcd_a, hold_a[15:0]);
        chk("ovf_a", ovf_a, hold_a[16]);
        chk("bcd_b", bcd_b, hold_b[7:0]);
        chk("ovf_b", ovf_b, hold_b[16]);
    end

    initial begin
        do_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed values, including the 2-digit overflow boundary.
        convert(1023);
        convert(0);
        convert(999);
        convert(5);
        convert(100);
        convert(99);

        // Back-to-back: start held, new value presented in the done cycle.
        bin_in = 10'd512;
        start  = 1'b1;
        tick();
        repeat (WIDTH) tick();
        bin_in = 10'd37;
        tick();
        start  = 1'b0;
        repeat (WIDTH + 2) tick();

        // Start while busy is ignored.
        bin_in = 10'd200;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        bin_in = 10'd100;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (WIDTH + 2) tick();

        // Reset four cycles into a conversion aborts it.
        bin_in = 10'd777;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        do_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (WIDTH + 3) tick();
        convert(42);

        // Randomized traffic, biased toward values near the 2-digit limit.
        for (int i = 0; i < 900; i++) begin
            start  = (($urandom % 4) == 0);
            bin_in = ($urandom % 2) ? WIDTH'($urandom_range(0, 120))
                                    : WIDTH'($urandom_range(0, 1023));
            tick();
        end
        start = 1'b0;
        repeat (WIDTH + 3) tick();

        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
